// File: rtl/mul8_pkg.sv
// mul8_pkg: column geometry of the 8x8 partial-product bus, shared with the compressor wrapper
package mul8_pkg;
    localparam int NCOLS = 15;
    localparam int NBITS = 64;
    localparam int COL_BASE [NCOLS] = '{0, 1, 3, 6, 10, 15, 21, 28, 36, 43, 49, 54, 58, 61, 63};
    function automatic int col_w(input int k);
        return (k < 8) ? k + 1 : NCOLS - k;
    endfunction
endpackage

// File: rtl/mul8_pp_array.sv
// mul8_pp_array: combinational 8x8 AND array flattened into weight-column order
module mul8_pp_array
    import mul8_pkg::*;
(
    input  logic [7:0]       a_i,
    input  logic [7:0]       b_i,
    output logic [NBITS-1:0] pp_o
);
    for (genvar i = 0; i < 8; i++) begin : g_i
        for (genvar j = 0; j < 8; j++) begin : g_j
            localparam int k = i + j;
            // upper columns start at i = k-7, so the in-column index is rebased there
            assign pp_o[COL_BASE[k] + i - ((k > 7) ? k - 7 : 0)] = a_i[i] & b_i[j];
        end
    end
endmodule

// File: rtl/mul8_ppgen.sv
// mul8_ppgen: two-stage elastic partial-product generator feeding the GPC compressor tree
// Define PPGEN_REF_EN to add out_ref, the registered a*b golden value.
module mul8_ppgen
    import mul8_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] out_cols,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] acc_count
`ifdef PPGEN_REF_EN
    ,
    output logic [15:0]      out_ref
`endif
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [7:0]       a_q, b_q;
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
    logic [NBITS-1:0] pp, cols_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_load, s2_load, s2_adv, in_fire;

    // a stage may load when empty or when it empties forward this same cycle
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign s2_adv   = s2_load && s1_valid_q;
    assign in_ready = s1_load;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_load ? in_fire : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        cnt_d      = cnt_q + CNT_W'(in_fire);
    end

    mul8_pp_array u_pp (
        .a_i  (a_q),
        .b_i  (b_q),
        .pp_o (pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s1_tag_q   <= '0;
            s2_tag_q   <= '0;
            cols_q     <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
            if (in_fire) begin
                a_q      <= in_a;
                b_q      <= in_b;
                s1_tag_q <= in_tag;
            end
            if (s2_adv) begin
                cols_q   <= pp;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_cols  = cols_q;
    assign out_tag   = s2_tag_q;
    assign acc_count = cnt_q;

`ifdef PPGEN_REF_EN
    logic [15:0] s1_ref_q, s2_ref_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ref_q <= '0;
            s2_ref_q <= '0;
        end else begin
            if (in_fire) s1_ref_q <= 16'(in_a) * 16'(in_b);
            if (s2_adv) s2_ref_q <= s1_ref_q;
        end
    end
    assign out_ref = s2_ref_q;
`endif
endmodule

// File: tb/tb_mul8_ppgen.sv
// tb_mul8_ppgen: directed vectors plus a random scoreboard run for mul8_ppgen
// A second instance with CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_mul8_ppgen;
    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_a = '0, in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        in_ready, out_valid, in_ready4, out_valid4;
    logic [63:0] out_cols, cols4;
    logic [3:0]  out_tag, tag4;
    logic [15:0] acc_count;
    logic [3:0]  acc4;
`ifdef PPGEN_REF_EN
    logic [15:0] out_ref, ref4;
`endif
    int          n_checks = 0, n_fail = 0, n_acc = 0;
    logic [19:0] sb [$];

    always #5 clk = ~clk;

    mul8_ppgen #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_cols(out_cols), .out_tag(out_tag),
        .acc_count(acc_count)
`ifdef PPGEN_REF_EN
        , .out_ref(out_ref)
`endif
    );

    mul8_ppgen #(.TAG_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid4),
        .out_ready(out_ready), .out_cols(cols4), .out_tag(tag4),
        .acc_count(acc4)
`ifdef PPGEN_REF_EN
        , .out_ref(ref4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_cols(input logic [7:0] a, input logic [7:0] b);
        logic [63:0] c = '0;
        int base = 0;
        for (int k = 0; k < 15; k++) begin
            int w = (k < 8) ? k + 1 : 15 - k;
            int lo = (k > 7) ? k - 7 : 0;
            for (int x = 0; x < w; x++) c[base + x] = a[lo + x] & b[k - lo - x];
            base += w;
        end
        return c;
    endfunction

    function automatic logic [63:0] col_sum(input logic [63:0] c);
        logic [63:0] s = '0;
        int base = 0;
        for (int k = 0; k < 15; k++) begin
            int w = (k < 8) ? k + 1 : 15 - k;
            for (int x = 0; x < w; x++) s += 64'(c[base + x]) << k;
            base += w;
        end
        return s;
    endfunction

    task automatic pop_check();
        logic [19:0] e;
        chk("out_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("cols", out_cols, exp_cols(e[15:8], e[7:0]));
        chk("tag", 64'(out_tag), 64'(e[19:16]));
        chk("sum", col_sum(out_cols), 64'(e[15:8]) * 64'(e[7:0]));
        chk("u4_valid", 64'(out_valid4), 64'd1);
        chk("u4_cols", cols4, exp_cols(e[15:8], e[7:0]));
        chk("u4_tag", 64'(tag4), 64'(e[19:16]));
`ifdef PPGEN_REF_EN
        chk("ref", 64'(out_ref), 64'(e[15:8]) * 64'(e[7:0]));
        chk("u4_ref", 64'(ref4), 64'(e[15:8]) * 64'(e[7:0]));
`endif
    endtask

    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] t, input logic r);
        in_valid = v; in_a = a; in_b = b; in_tag = t; out_ready = r;
        #1;
        chk("in_ready", 64'(in_ready), 64'(!(sb.size() == 2 && !r)));
        chk("u4_in_ready", 64'(in_ready4), 64'(!(sb.size() == 2 && !r)));
        if (out_valid && out_ready) pop_check();
        if (in_valid && in_ready) begin
            sb.push_back({t, a, b});
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        sb.delete();
        n_acc = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [63:0] exp);
        cycle(1'b1, a, b, 4'hA, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk(name, out_cols, exp);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
    endtask

    initial begin
        int cyc;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cols", out_cols, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_acc", 64'(acc_count), 64'd0);
`ifdef PPGEN_REF_EN
        chk("rst_ref", 64'(out_ref), 64'd0);
`endif
        #1 rst = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        cycle(1'b1, 8'hFF, 8'hFF, 4'h5, 1'b1);
        chk("ff_stage1_not_out", 64'(out_valid), 64'd0);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk("ff_valid", 64'(out_valid), 64'd1);
        chk("ff_cols", out_cols, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ff_tag", 64'(out_tag), 64'd5);
        chk("ff_acc", 64'(acc_count), 64'd1);
`ifdef PPGEN_REF_EN
        chk("ff_ref", 64'(out_ref), 64'hFE01);
`endif
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk("ff_drained", 64'(out_valid), 64'd0);

        single("bit28", 8'h01, 8'h80, 64'h0000_0000_1000_0000);
        single("bit35", 8'h80, 8'h01, 64'h0000_0008_0000_0000);
        single("bit63", 8'h80, 8'h80, 64'h8000_0000_0000_0000);
        single("bit0", 8'h01, 8'h01, 64'h0000_0000_0000_0001);

        cycle(1'b1, 8'h11, 8'h22, 4'd1, 1'b0);
        cycle(1'b1, 8'h33, 8'h44, 4'd2, 1'b0);
        cycle(1'b1, 8'h55, 8'h66, 4'd3, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_hold_tag", 64'(out_tag), 64'd1);
        cycle(1'b1, 8'h55, 8'h66, 4'd3, 1'b0);
        chk("bp_hold_cols", out_cols, exp_cols(8'h11, 8'h22));
        chk("bp_acc", 64'(acc_count), 64'd7);
        cycle(1'b1, 8'h55, 8'h66, 4'd3, 1'b1);
        chk("bp_next_tag", 64'(out_tag), 64'd2);
        chk("bp_occupancy", 64'(sb.size()), 64'd2);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk("bp_last_tag", 64'(out_tag), 64'd3);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        cycle(1'b1, 8'hA5, 8'h5A, 4'd7, 1'b0);
        cycle(1'b1, 8'hC3, 8'h3C, 4'd8, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_cols", out_cols, 64'd0);
        chk("midrst_acc", 64'(acc_count), 64'd0);
        sb.delete();
        n_acc = 0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_empty", 64'(out_valid), 64'd0);
        cycle(1'b1, 8'h12, 8'h34, 4'd9, 1'b1);
        chk("postrst_stage1", 64'(out_valid), 64'd0);
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk("postrst_valid", 64'(out_valid), 64'd1);
        chk("postrst_tag", 64'(out_tag), 64'd9);
        chk("postrst_cols", out_cols, exp_cols(8'h12, 8'h34));
        cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);

        do_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 8'(i + 3), 4'(i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk("wrap_acc4", 64'(acc4), 64'd1);
        chk("wrap_acc16", 64'(acc_count), 64'd17);

        do_reset();
        cyc = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  4'($urandom), 1'($urandom_range(0, 1)));
            cyc++;
        end
        chk("rand_budget", 64'(cyc < 60000), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 8'h00, 4'h0, 1'b1);
        chk("rand_sb_empty", 64'(sb.size()), 64'd0);
        chk("rand_acc16", 64'(acc_count), 64'd10000);
        chk("rand_acc4", 64'(acc4), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
